// File: rtl/oh_fifo_pkg.sv
// Shared constants and helpers for the oh_fifo family of synchronous FIFOs.
package oh_fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Pointers wrap by comparison so that non power-of-2 depths work.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        int unsigned nxt;
        if (ptr == depth - 32'd1) begin
            nxt = 32'd0;
        end else begin
            nxt = ptr + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/oh_fifo_fwft_skid.sv
// Two-entry fall-through output stage behind a RAM with one cycle of read
// latency; a word returning from the RAM is presented directly when the stage is empty.
module oh_fifo_fwft_skid #(
    parameter int DW = 104
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          flush_i,
    input  logic          ram_avail_i,
    input  logic [DW-1:0] ram_data_i,
    input  logic          pop_i,
    output logic          issue_o,
    output logic [1:0]    occ_o,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);

    logic [1:0]    cnt_q, cnt_d;
    logic          infl_q, infl_d;
    logic [DW-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic [1:0]    occ_s;
    logic [DW-1:0] item0_s, item1_s;
    logic          pop_s;

    // Occupancy counts buffered words plus the word still in the RAM pipe.
    assign occ_s   = cnt_q + {1'b0, infl_q};
    assign item0_s = (cnt_q != 2'd0) ? buf0_q : ram_data_i;
    assign item1_s = (cnt_q == 2'd2) ? buf1_q : ram_data_i;
    assign pop_s   = pop_i & (occ_s != 2'd0);

    // Next-state: land the in-flight word, drop the popped head, refill
    always_comb begin
        issue_o = 1'b0;
        cnt_d   = cnt_q;
        infl_d  = infl_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        if (flush_i) begin
            cnt_d  = 2'd0;
            infl_d = 1'b0;
        end else begin
            issue_o = ram_avail_i & ((occ_s < 2'd2) | pop_s);
            cnt_d   = occ_s - {1'b0, pop_s};
            infl_d  = issue_o;
            if (pop_s) begin
                buf0_d = item1_s;
            end else begin
                buf0_d = item0_s;
            end
            buf1_d = item1_s;
        end
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (!nreset) begin
            cnt_q  <= 2'd0;
            infl_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            infl_q <= infl_d;
        end
    end

    // Data holding registers
    always_ff @(posedge clk) begin
        buf0_q <= buf0_d;
        buf1_q <= buf1_d;
    end

    assign occ_o   = occ_s;
    assign valid_o = (occ_s != 2'd0);
    assign data_o  = item0_s;

endmodule

// File: rtl/oh_memory_dp.sv
// Generic dual-port RAM: bit-masked synchronous write, registered read.
module oh_memory_dp #(
    parameter int DW    = 104,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          wr_clk,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_wem,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_din,
    input  logic          rd_clk,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dout
);

    logic [DW-1:0] ram_q [DEPTH];

    // Masked write port
    always_ff @(posedge wr_clk) begin
        if (wr_en) begin
            ram_q[wr_addr] <= (ram_q[wr_addr] & ~wr_wem) | (wr_din & wr_wem);
        end
    end

    // Read port; output holds its value when no read is issued
    always_ff @(posedge rd_clk) begin
        if (rd_en) begin
            rd_dout <= ram_q[rd_addr];
        end
    end

endmodule

// File: rtl/oh_fifo_sync_ext.sv
// Synchronous FIFO with arbitrary depth, optional fall-through output,
// programmable watermarks, sticky error flags and synchronous flush.
module oh_fifo_sync_ext
    import oh_fifo_pkg::*;
#(
    parameter int DW         = 104,
    parameter int DEPTH      = 32,
    parameter int PROG_FULL  = DEPTH / 2,
    parameter int PROG_EMPTY = 1,
    parameter int FWFT       = FIFO_MODE_STD,
    parameter int AW         = clog2(DEPTH),
    parameter int CW         = clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          clear,
    input  logic [DW-1:0] din,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic [DW-1:0] dout,
    output logic          valid,
    output logic          full,
    output logic          prog_full,
    output logic          empty,
    output logic          prog_empty,
    output logic          overflow,
    output logic          underflow,
    output logic [CW-1:0] count
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d, prog_full_q, prog_full_d;
    logic          prog_empty_q, prog_empty_d;
    logic          overflow_q, overflow_d, underflow_q, underflow_d;
    logic          wr_ok_s, rd_ok_s, empty_s, ram_rd_s, out_valid_s;
    logic [DW-1:0] ram_dout_s, out_data_s, wem_s;

    assign wem_s   = {DW{1'b1}};
    assign wr_ok_s = wr_en & ~full_q & ~clear;
    assign rd_ok_s = rd_en & ~empty_s & ~clear;

    // Pointer, count and sticky-flag next state; flush wins over requests
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear) begin
            wr_ptr_d    = AW'(0);
            rd_ptr_d    = AW'(0);
            count_d     = CW'(0);
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_d = AW'(wrap_inc(32'(wr_ptr_q), DEPTH));
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (ram_rd_s) begin
                rd_ptr_d = AW'(wrap_inc(32'(rd_ptr_q), DEPTH));
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            overflow_d  = overflow_q | (wr_en & full_q);
            underflow_d = underflow_q | (rd_en & empty_s);
        end
        full_d       = (count_d == CW'(DEPTH));
        prog_full_d  = (count_d >= CW'(PROG_FULL));
        prog_empty_d = (count_d <= CW'(PROG_EMPTY));
    end

    // State and status registers
    always_ff @(posedge clk) begin
        if (!nreset) begin
            wr_ptr_q     <= AW'(0);
            rd_ptr_q     <= AW'(0);
            count_q      <= CW'(0);
            full_q       <= 1'b0;
            prog_full_q  <= 1'b0;
            prog_empty_q <= 1'b1;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            full_q       <= full_d;
            prog_full_q  <= prog_full_d;
            prog_empty_q <= prog_empty_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    oh_memory_dp #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .wr_clk  (clk),
        .wr_en   (wr_ok_s),
        .wr_wem  (wem_s),
        .wr_addr (wr_ptr_q),
        .wr_din  (din),
        .rd_clk  (clk),
        .rd_en   (ram_rd_s),
        .rd_addr (rd_ptr_q),
        .rd_dout (ram_dout_s)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            logic [1:0] skid_occ_s;
            logic       ram_avail_s;

            // Words still in the RAM are those not yet handed to the skid stage.
            assign ram_avail_s = (count_q > CW'(skid_occ_s));

            oh_fifo_fwft_skid #(
                .DW (DW)
            ) u_skid (
                .clk         (clk),
                .nreset      (nreset),
                .flush_i     (clear),
                .ram_avail_i (ram_avail_s),
                .ram_data_i  (ram_dout_s),
                .pop_i       (rd_ok_s),
                .issue_o     (ram_rd_s),
                .occ_o       (skid_occ_s),
                .valid_o     (out_valid_s),
                .data_o      (out_data_s)
            );

            assign empty_s = ~out_valid_s;
        end else begin : g_std
            logic valid_q, empty_q;

            // Read data appears one cycle after an accepted read
            always_ff @(posedge clk) begin
                if (!nreset) begin
                    valid_q <= 1'b0;
                    empty_q <= 1'b1;
                end else begin
                    valid_q <= rd_ok_s;
                    empty_q <= (count_d == CW'(0));
                end
            end

            assign ram_rd_s    = rd_ok_s;
            assign out_valid_s = valid_q;
            assign out_data_s  = ram_dout_s;
            assign empty_s     = empty_q;
        end
    endgenerate

    assign dout       = out_data_s;
    assign valid      = out_valid_s;
    assign full       = full_q;
    assign prog_full  = prog_full_q;
    assign empty      = empty_s;
    assign prog_empty = prog_empty_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
    assign count      = count_q;

endmodule

// File: tb/tb_oh_fifo_sync_ext.sv
// Directed bench for oh_fifo_sync_ext: standard mode at depth 32 and 24,
// fall-through mode at depth 24, all sharing one stimulus stream.
module tb_oh_fifo_sync_ext;

    localparam int DW  = 104;
    localparam int S32 = 0;
    localparam int S24 = 1;
    localparam int F24 = 2;

    logic          clk, nreset, clear, wr_en, rd_en;
    logic [DW-1:0] din;
    logic [DW-1:0] dout_s [3];
    logic          valid_s [3];
    logic          full_s [3];
    logic          pfull_s [3];
    logic          empty_s [3];
    logic          pempty_s [3];
    logic          ovf_s [3];
    logic          udf_s [3];
    logic [5:0]    cnt_s32;
    logic [4:0]    cnt_s24, cnt_f24;

    int n_total = 0;
    int n_bad   = 0;

    oh_fifo_sync_ext #(.DW(DW)) u_s32 (
        .clk(clk), .nreset(nreset), .clear(clear), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout_s[S32]), .valid(valid_s[S32]), .full(full_s[S32]), .prog_full(pfull_s[S32]),
        .empty(empty_s[S32]), .prog_empty(pempty_s[S32]), .overflow(ovf_s[S32]),
        .underflow(udf_s[S32]), .count(cnt_s32)
    );

    oh_fifo_sync_ext #(.DW(DW), .DEPTH(24)) u_s24 (
        .clk(clk), .nreset(nreset), .clear(clear), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout_s[S24]), .valid(valid_s[S24]), .full(full_s[S24]), .prog_full(pfull_s[S24]),
        .empty(empty_s[S24]), .prog_empty(pempty_s[S24]), .overflow(ovf_s[S24]),
        .underflow(udf_s[S24]), .count(cnt_s24)
    );

    oh_fifo_sync_ext #(.DW(DW), .DEPTH(24), .FWFT(1)) u_f24 (
        .clk(clk), .nreset(nreset), .clear(clear), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout_s[F24]), .valid(valid_s[F24]), .full(full_s[F24]), .prog_full(pfull_s[F24]),
        .empty(empty_s[F24]), .prog_empty(pempty_s[F24]), .overflow(ovf_s[F24]),
        .underflow(udf_s[F24]), .count(cnt_f24)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        clear  = 1'b0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        step();
        nreset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        nreset = 1'b0;
        clear  = 1'b0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        din    = '0;
        step();
        step();
        nreset = 1'b1;

        // reset state of every instance
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("rst_valid%0d", i),  128'(valid_s[i]),  128'd0);
            check_eq($sformatf("rst_empty%0d", i),  128'(empty_s[i]),  128'd1);
            check_eq($sformatf("rst_full%0d", i),   128'(full_s[i]),   128'd0);
            check_eq($sformatf("rst_pfull%0d", i),  128'(pfull_s[i]),  128'd0);
            check_eq($sformatf("rst_pempty%0d", i), 128'(pempty_s[i]), 128'd1);
            check_eq($sformatf("rst_ovf%0d", i),    128'(ovf_s[i]),    128'd0);
            check_eq($sformatf("rst_udf%0d", i),    128'(udf_s[i]),    128'd0);
        end
        check_eq("rst_cnt_s32", 128'(cnt_s32), 128'd0);
        check_eq("rst_cnt_f24", 128'(cnt_f24), 128'd0);

        // fill depth-32 standard FIFO, 33rd write overflows
        for (int i = 0; i < 33; i++) begin
            wr_en = 1'b1;
            din   = DW'(i);
            step();
            if (i == 14) check_eq("t1_pfull_15", 128'(pfull_s[S32]), 128'd0);
            if (i == 15) check_eq("t1_pfull_16", 128'(pfull_s[S32]), 128'd1);
            if (i == 30) check_eq("t1_full_31", 128'(full_s[S32]), 128'd0);
            if (i == 31) begin
                check_eq("t1_full_32", 128'(full_s[S32]), 128'd1);
                check_eq("t1_cnt_32", 128'(cnt_s32), 128'd32);
                check_eq("t1_ovf_pre", 128'(ovf_s[S32]), 128'd0);
            end
            if (i == 32) begin
                check_eq("t1_ovf", 128'(ovf_s[S32]), 128'd1);
                check_eq("t1_cnt_hold", 128'(cnt_s32), 128'd32);
            end
        end
        wr_en = 1'b0;

        // drain with 33 reads
        rd_en = 1'b1;
        for (int k = 0; k < 33; k++) begin
            step();
            if (k == 0) begin
                check_eq("t2_full_drop", 128'(full_s[S32]), 128'd0);
                check_eq("t2_cnt_31", 128'(cnt_s32), 128'd31);
            end
            if (k < 32) begin
                check_eq($sformatf("t2_dout%0d", k), 128'(dout_s[S32]), 128'(k));
                check_eq($sformatf("t2_valid%0d", k), 128'(valid_s[S32]), 128'd1);
            end
            if (k == 31) begin
                check_eq("t2_empty", 128'(empty_s[S32]), 128'd1);
                check_eq("t2_cnt_0", 128'(cnt_s32), 128'd0);
                check_eq("t2_udf_pre", 128'(udf_s[S32]), 128'd0);
            end
            if (k == 32) begin
                check_eq("t2_udf", 128'(udf_s[S32]), 128'd1);
                check_eq("t2_valid_end", 128'(valid_s[S32]), 128'd0);
            end
        end
        rd_en = 1'b0;

        // fall-through latency: write at N, visible at N+2
        do_reset();
        wr_en = 1'b1;
        din   = DW'(8'hA5);
        step();
        wr_en = 1'b0;
        check_eq("t3_valid_n1", 128'(valid_s[F24]), 128'd0);
        step();
        check_eq("t3_valid_n2", 128'(valid_s[F24]), 128'd1);
        check_eq("t3_empty_n2", 128'(empty_s[F24]), 128'd0);
        check_eq("t3_dout_n2", 128'(dout_s[F24]), 128'hA5);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check_eq("t3_empty_n3", 128'(empty_s[F24]), 128'd1);
        check_eq("t3_valid_n3", 128'(valid_s[F24]), 128'd0);
        check_eq("t3_cnt_n3", 128'(cnt_f24), 128'd0);

        // fall-through streaming after a two-word fill
        wr_en = 1'b1;
        din   = DW'(0);
        step();
        din = DW'(1);
        step();
        check_eq("t4_fill_valid", 128'(valid_s[F24]), 128'd1);
        check_eq("t4_fill_dout", 128'(dout_s[F24]), 128'd0);
        check_eq("t4_fill_cnt", 128'(cnt_f24), 128'd2);
        rd_en = 1'b1;
        for (int j = 0; j < 100; j++) begin
            din = DW'(j + 2);
            step();
            check_eq($sformatf("t4_dout%0d", j), 128'(dout_s[F24]), 128'(j + 1));
            check_eq($sformatf("t4_cnt%0d", j), 128'(cnt_f24), 128'd2);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_eq("t4_udf", 128'(udf_s[F24]), 128'd0);
        check_eq("t4_ovf", 128'(ovf_s[F24]), 128'd0);

        // depth-24 fill/drain passes in both modes
        do_reset();
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 24; i++) begin
                wr_en = 1'b1;
                din   = DW'(p * 100 + i);
                step();
                if (i == 22) begin
                    check_eq($sformatf("t5_s_full23_p%0d", p), 128'(full_s[S24]), 128'd0);
                    check_eq($sformatf("t5_f_full23_p%0d", p), 128'(full_s[F24]), 128'd0);
                end
                if (i == 23) begin
                    check_eq($sformatf("t5_s_full_p%0d", p), 128'(full_s[S24]), 128'd1);
                    check_eq($sformatf("t5_f_full_p%0d", p), 128'(full_s[F24]), 128'd1);
                    check_eq($sformatf("t5_s_cnt_p%0d", p), 128'(cnt_s24), 128'd24);
                    check_eq($sformatf("t5_f_cnt_p%0d", p), 128'(cnt_f24), 128'd24);
                end
            end
            wr_en = 1'b0;
            rd_en = 1'b1;
            for (int i = 0; i < 24; i++) begin
                check_eq($sformatf("t5_f_dout_p%0d_%0d", p, i), 128'(dout_s[F24]), 128'(p * 100 + i));
                step();
                check_eq($sformatf("t5_s_dout_p%0d_%0d", p, i), 128'(dout_s[S24]), 128'(p * 100 + i));
            end
            rd_en = 1'b0;
            check_eq($sformatf("t5_s_empty_p%0d", p), 128'(empty_s[S24]), 128'd1);
            check_eq($sformatf("t5_f_empty_p%0d", p), 128'(empty_s[F24]), 128'd1);
            check_eq($sformatf("t5_s_cnt0_p%0d", p), 128'(cnt_s24), 128'd0);
            check_eq($sformatf("t5_f_cnt0_p%0d", p), 128'(cnt_f24), 128'd0);
        end

        // clear with a colliding write, sticky flags set beforehand
        do_reset();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check_eq("t6_udf_set", 128'(udf_s[S32]), 128'd1);
        for (int i = 0; i < 25; i++) begin
            wr_en = 1'b1;
            din   = DW'(i);
            step();
        end
        wr_en = 1'b0;
        check_eq("t6_ovf_set", 128'(ovf_s[S24]), 128'd1);
        check_eq("t6_cnt25", 128'(cnt_s32), 128'd25);
        rd_en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
        end
        rd_en = 1'b0;
        check_eq("t6_cnt10", 128'(cnt_s32), 128'd10);
        check_eq("t6_valid_pre", 128'(valid_s[S32]), 128'd1);
        clear = 1'b1;
        wr_en = 1'b1;
        din   = DW'(16'hBEEF);
        step();
        clear = 1'b0;
        wr_en = 1'b0;
        check_eq("t6_cnt_clr", 128'(cnt_s32), 128'd0);
        check_eq("t6_empty_clr", 128'(empty_s[S32]), 128'd1);
        check_eq("t6_valid_clr", 128'(valid_s[S32]), 128'd0);
        check_eq("t6_pempty_clr", 128'(pempty_s[S32]), 128'd1);
        check_eq("t6_ovf_clr", 128'(ovf_s[S24]), 128'd0);
        check_eq("t6_udf_clr", 128'(udf_s[S32]), 128'd0);
        check_eq("t6_f_valid_clr", 128'(valid_s[F24]), 128'd0);
        step();
        check_eq("t6_cnt_after", 128'(cnt_s32), 128'd0);

        // reset mid-stream on fall-through FIFO discards the in-flight word
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            din   = DW'(i + 16'h300);
            step();
        end
        wr_en = 1'b0;
        check_eq("t6b_valid_pre", 128'(valid_s[F24]), 128'd1);
        check_eq("t6b_dout_pre", 128'(dout_s[F24]), 128'h300);
        check_eq("t6b_cnt_pre", 128'(cnt_f24), 128'd3);
        nreset = 1'b0;
        step();
        nreset = 1'b1;
        check_eq("t6b_valid_rst", 128'(valid_s[F24]), 128'd0);
        check_eq("t6b_empty_rst", 128'(empty_s[F24]), 128'd1);
        check_eq("t6b_cnt_rst", 128'(cnt_f24), 128'd0);
        step();
        check_eq("t6b_valid_idle", 128'(valid_s[F24]), 128'd0);
        wr_en = 1'b1;
        din   = DW'(8'h77);
        step();
        wr_en = 1'b0;
        step();
        check_eq("t6b_valid_new", 128'(valid_s[F24]), 128'd1);
        check_eq("t6b_dout_new", 128'(dout_s[F24]), 128'h77);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
